// File: rtl/fact_pkg.sv
// Shared definitions for the factorial host controller and the factorial core:
// FSM state encoding, default operand/result widths and a counter sizing helper.
package fact_pkg;

  localparam int FACT_N_W   = 4;
  localparam int FACT_RES_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fact_state_e;

  // Width needed to hold values 0..limit, never less than one bit.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fact_timeout_cnt.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags
// expiry on the LIMIT-th enabled cycle (the counter saturates there).
module fact_timeout_cnt
  import fact_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(LIMIT);

  logic [CW-1:0] count_reg;

  // count_reg holds (cycles already spent in WAIT), so the LIMIT-th WAIT cycle sees LIMIT-1.
  assign expired = (count_reg == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fact_host_ctrl.sv
// Host-side command/response controller for a factorial core (IDLE/ISSUE/WAIT/RESP).
// Define FACT_HOST_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYCLES cycles.
module fact_host_ctrl
  import fact_pkg::*;
#(
  parameter int N_W            = FACT_N_W,
  parameter int RES_W          = FACT_RES_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N_W-1:0]   cmd_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_error,
  output logic             rsp_timeout,
  output logic             core_go,
  output logic [N_W-1:0]   core_n,
  input  logic             core_done,
  input  logic             core_error,
  input  logic [RES_W-1:0] core_result,
  output logic             busy,
  output logic [1:0]       state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fact_host_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  fact_state_e      state_reg;
  logic             core_go_reg;
  logic [N_W-1:0]   core_n_reg;
  logic             rsp_valid_reg;
  logic [RES_W-1:0] rsp_result_reg;
  logic             rsp_error_reg;
  logic             rsp_timeout_reg;
  logic             busy_reg;
  logic             timeout_expired;

`ifdef FACT_HOST_TIMEOUT_EN
  fact_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg == ST_ISSUE),
    .enable  (state_reg == ST_WAIT),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      core_go_reg     <= 1'b0;
      core_n_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_result_reg  <= '0;
      rsp_error_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      core_go_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            core_n_reg  <= cmd_n;
            core_go_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          // Core error outranks done, and any core flag outranks the watchdog.
          if (core_error) begin
            rsp_result_reg  <= '0;
            rsp_error_reg   <= 1'b1;
            rsp_timeout_reg <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= ST_RESP;
          end else if (core_done) begin
            rsp_result_reg  <= core_result;
            rsp_error_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= ST_RESP;
          end else if (timeout_expired) begin
            rsp_result_reg  <= '0;
            rsp_error_reg   <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign core_go     = core_go_reg;
  assign core_n      = core_n_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_result  = rsp_result_reg;
  assign rsp_error   = rsp_error_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign busy        = busy_reg;
  assign state       = state_reg;

endmodule

// File: doc/fact_host_ctrl.md
FACT_HOST_CTRL -- requirements
Module: fact_host_ctrl

Interface
REQ-001 SHALL have parameter N_W, default 4: width of operand n.
REQ-002 SHALL have parameter RES_W, default 32: width of factorial result.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before abort.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  host offers operand.
REQ-007 SHALL have port cmd_ready  output  1  block accepts operand.
REQ-008 SHALL have port cmd_n  input  N_W  operand n.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  host consumes response.
REQ-011 SHALL have port rsp_result  output  RES_W  n! or 0 on any error.
REQ-012 SHALL have port rsp_error  output  1  core error or timeout.
REQ-013 SHALL have port rsp_timeout  output  1  error was caused by timeout.
REQ-014 SHALL have port core_go  output  1  one-cycle start pulse to the factorial core.
REQ-015 SHALL have port core_n  output  N_W  operand to the core, held stable from ISSUE to RESP.
REQ-016 SHALL have port core_done / core_error  input  1 each  core completion flags.
REQ-017 SHALL have port core_result  input  RES_W  core product.
REQ-018 SHALL have port busy  output  1  high in any state except IDLE.
REQ-019 SHALL have port state  output  2  current state encoding.

Function
REQ-020 SHALL implement states IDLE=0, ISSUE=1, WAIT=2, RESP=3.
REQ-021 IDLE: cmd_ready=1; on cmd_valid, latch cmd_n into core_n and go to ISSUE; otherwise stay.
REQ-022 ISSUE: core_go=1 for exactly this cycle; clear timeout counter; go to WAIT unconditionally.
REQ-023 WAIT: core_go=0; sample core_done/core_error each cycle, starting with the first WAIT cycle.
REQ-024 WAIT, core_error=1: rsp_error=1, rsp_result=0, go to RESP; error takes priority when core_done and core_error are high in the same cycle.
REQ-025 WAIT, core_done=1 only: latch core_result into rsp_result with rsp_error=0, then go to RESP.
REQ-026 RESP: rsp_valid=1 with all rsp_* held stable until rsp_ready=1; on that handshake cycle go to IDLE.
REQ-027 cmd_ready SHALL be 0 in ISSUE, WAIT and RESP; no command queueing, so a new command needs a return to IDLE.
REQ-028 Back-to-back throughput: minimum 4 cycles per command (IDLE, ISSUE, WAIT, RESP).
REQ-029 core_done/core_error outside WAIT SHALL be ignored.
REQ-030 rsp_timeout SHALL be 0 on every non-timeout response.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE and clear all registers, regardless of clock.
REQ-032 Reset values: cmd_ready=1 (combinational from IDLE), core_go=0, core_n=0, rsp_valid=0, rsp_result=0, rsp_error=0, rsp_timeout=0, busy=0, state=0.
REQ-033 Reset mid-operation SHALL discard the pending command with no response issued.

Configuration
REQ-034 Macro FACT_HOST_TIMEOUT_EN, when defined, SHALL enable the watchdog: if WAIT lasts TIMEOUT_CYCLES cycles with no core flag, go to RESP with rsp_error=1, rsp_timeout=1, rsp_result=0.
REQ-035 When FACT_HOST_TIMEOUT_EN is defined, a core flag on the expiry cycle SHALL win over the timeout.
REQ-036 When FACT_HOST_TIMEOUT_EN is undefined, WAIT SHALL persist indefinitely, rsp_timeout SHALL be tied 0, and no counter logic SHALL be synthesized.

Structure
REQ-037 Package fact_pkg SHALL hold the state encodings and the default N_W/RES_W constants shared with the factorial core.
REQ-038 The watchdog counter SHALL be the sub-module fact_timeout_cnt (clear, enable, expired), instantiated only under FACT_HOST_TIMEOUT_EN.

Verification
REQ-039 Send n=5, core_done 6 cycles after go with core_result=120 -> one core_go pulse, rsp_valid with rsp_result=120, rsp_error=0.
REQ-040 Send n=13, core_error in the 2nd WAIT cycle -> rsp_error=1, rsp_result=0, rsp_timeout=0.
REQ-041 Hold rsp_ready=0 for 10 cycles after a response -> rsp_* stable, cmd_ready=0; accepted on the cycle rsp_ready=1.
REQ-042 Assert core_done and core_error in the same cycle with core_result=24 -> rsp_error=1, rsp_result=0.
REQ-043 With FACT_HOST_TIMEOUT_EN, no core flag for 64 WAIT cycles -> rsp_error=1, rsp_timeout=1; without the macro, still in WAIT at cycle 200.
REQ-044 Pulse reset_n low during WAIT, then send n=3 with result 6 -> immediate IDLE with no stale response; next command returns 6.
